// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command sequencer: opcodes, FSM states
// and error flag bit positions.
package spi_cmd_pkg;

  localparam logic [7:0] OP_WR_INC = 8'h02;  // burst write, address auto-increments
  localparam logic [7:0] OP_WR_FIX = 8'h03;  // burst write to one fixed address
  localparam logic [7:0] OP_NOP    = 8'h00;  // accepted, payload ignored

  localparam int ERR_BAD_OP = 0;
  localparam int ERR_OVR    = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_DATA,
    ST_DISCARD
  } state_t;

endpackage

// File: rtl/spi_cmd_ss_sync.sv
// Synchronizes the raw active-low SPI slave select into the clk domain and
// turns its edges into one-cycle frame_start (falling) / frame_end (rising)
// pulses. All flops reset to 1 (deselected) so reset never fakes a frame.
module spi_cmd_ss_sync #(
  parameter int SS_SYNC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_ss,
  output logic frame_start,
  output logic frame_end
);

  logic [SS_SYNC-1:0] sync_q;
  logic               prev_q;

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SS_SYNC-2:0], spi_ss};
      prev_q <= sync_q[SS_SYNC-1];
    end
  end

  assign frame_start = prev_q & ~sync_q[SS_SYNC-1];
  assign frame_end   = ~prev_q & sync_q[SS_SYNC-1];

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: frames the spi_slave byte stream with slave select,
// decodes opcode + 16-bit address and issues one bus write per data byte.
// Write slot handshake: wr_vld_o/wr_addr_o/wr_data_o hold steady while
// wr_vld_o=1 and wr_rdy_i=0; a write transfers in a cycle with both high.
// Optional statistics counters are built when SPI_CMD_STATS_EN is defined;
// otherwise frame_cnt_o / err_cnt_o are tied to zero.
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int SS_SYNC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_ss,
  input  logic              byte_vld_i,
  input  logic [7:0]        byte_i,
  output logic              wr_vld_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  input  logic              wr_rdy_i,
  output logic              busy_o,
  output logic [1:0]        err_o,
  input  logic              err_clr_i,
  output logic [15:0]       frame_cnt_o,
  output logic [15:0]       err_cnt_o
);

  logic frame_start;
  logic frame_end;

  spi_cmd_ss_sync #(.SS_SYNC(SS_SYNC)) u_ss_sync (
    .clk         (clk),
    .rst         (rst),
    .spi_ss      (spi_ss),
    .frame_start (frame_start),
    .frame_end   (frame_end)
  );

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              inc_q;
  logic              wr_vld_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [1:0]        err_q;

  logic ld_mode;   // capture addressing mode from opcode
  logic mode_inc;  // mode being captured: 1 = auto-increment
  logic ld_addr_h;
  logic ld_addr_l;
  logic ld_slot;   // data byte goes into the write slot
  logic ovr;       // data byte dropped, slot still occupied
  logic bad_op;

  // Next-state and per-byte decode; frame start/end override any byte.
  always_comb begin
    state_d   = state_q;
    ld_mode   = 1'b0;
    mode_inc  = 1'b0;
    ld_addr_h = 1'b0;
    ld_addr_l = 1'b0;
    ld_slot   = 1'b0;
    ovr       = 1'b0;
    bad_op    = 1'b0;
    if (frame_start) begin
      state_d = ST_CMD;
    end else if (frame_end) begin
      state_d = ST_IDLE;
    end else if (byte_vld_i) begin
      case (state_q)
        ST_CMD: begin
          case (byte_i)
            OP_WR_INC: begin
              state_d  = ST_ADDR_H;
              ld_mode  = 1'b1;
              mode_inc = 1'b1;
            end
            OP_WR_FIX: begin
              state_d = ST_ADDR_H;
              ld_mode = 1'b1;
            end
            OP_NOP:  state_d = ST_DISCARD;
            default: begin
              state_d = ST_DISCARD;
              bad_op  = 1'b1;
            end
          endcase
        end
        ST_ADDR_H: begin
          state_d   = ST_ADDR_L;
          ld_addr_h = 1'b1;
        end
        ST_ADDR_L: begin
          state_d   = ST_DATA;
          ld_addr_l = 1'b1;
        end
        ST_DATA: begin
          if (wr_vld_q && !wr_rdy_i) ovr = 1'b1;
          else                       ld_slot = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Address/mode capture, write slot and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      inc_q     <= 1'b0;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= '0;
    end else begin
      if (ld_mode)   inc_q  <= mode_inc;
      if (ld_addr_h) addr_q <= {byte_i, addr_q[7:0]};
      if (ld_addr_l) addr_q <= {addr_q[ADDR_W-1:8], byte_i};
      if (ld_slot) begin
        wr_vld_q  <= 1'b1;
        wr_addr_q <= addr_q;
        wr_data_q <= byte_i;
        if (inc_q) addr_q <= addr_q + ADDR_W'(1);
      end else if (wr_rdy_i) begin
        wr_vld_q <= 1'b0;
      end
      // A set in the same cycle as a clear survives the clear.
      err_q <= (err_clr_i ? 2'b00 : err_q) | {ovr, bad_op};
    end
  end

  assign wr_vld_o  = wr_vld_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign err_o     = err_q;
  assign busy_o    = (state_q != ST_IDLE) || wr_vld_q;

`ifdef SPI_CMD_STATS_EN
  logic        op_ok_q;
  logic        op_valid;
  logic [15:0] frame_cnt_q;
  logic [15:0] err_cnt_q;

  assign op_valid = (state_q == ST_CMD) && byte_vld_i && !frame_start && !frame_end &&
                    (byte_i == OP_WR_INC || byte_i == OP_WR_FIX || byte_i == OP_NOP);

  // Saturating frame / error event counters; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_ok_q     <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (frame_start || frame_end) op_ok_q <= 1'b0;
      else if (op_valid)            op_ok_q <= 1'b1;
      if (frame_end && op_ok_q && frame_cnt_q != 16'hFFFF)
        frame_cnt_q <= frame_cnt_q + 16'd1;
      if ((bad_op || ovr) && err_cnt_q != 16'hFFFF)
        err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign err_cnt_o   = err_cnt_q;
`else
  assign frame_cnt_o = 16'h0000;
  assign err_cnt_o   = 16'h0000;
`endif

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Testbench for spi_cmd_ctrl: directed frames from the test plan plus random
// frames, with a queue-based scoreboard fed by a frame-level reference model.
module tb_spi_cmd_ctrl;

  localparam int SS_SYNC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_ss;
  logic        byte_vld_i;
  logic [7:0]  byte_i;
  logic        wr_vld_o;
  logic [15:0] wr_addr_o;
  logic [7:0]  wr_data_o;
  logic        wr_rdy_i;
  logic        busy_o;
  logic [1:0]  err_o;
  logic        err_clr_i;
  logic [15:0] frame_cnt_o;
  logic [15:0] err_cnt_o;

  spi_cmd_ctrl #(.ADDR_W(16), .SS_SYNC(SS_SYNC)) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_ss      (spi_ss),
    .byte_vld_i  (byte_vld_i),
    .byte_i      (byte_i),
    .wr_vld_o    (wr_vld_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .wr_rdy_i    (wr_rdy_i),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .err_clr_i   (err_clr_i),
    .frame_cnt_o (frame_cnt_o),
    .err_cnt_o   (err_cnt_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_wr    = 0;
  logic [23:0] exp_q[$];     // {addr, data} of expected bus writes, in order
  logic [7:0]  frm_q[$];     // bytes of the frame being sent
  logic [1:0]  exp_err   = 2'b00;
  int          exp_frames = 0;
  int          exp_errs   = 0;
  logic        rdy_mode  = 1'b0;  // 1: random ready with bounded stalls
  logic        rdy_force = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a write transfers at the posedge following a negedge where
  // wr_vld_o and wr_rdy_i are both high.
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && wr_vld_o === 1'b1 && wr_rdy_i === 1'b1) begin
        n_wr++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got 0x%0h required none", {wr_addr_o, wr_data_o});
        end else begin
          e = exp_q.pop_front();
          chk("write", {8'h00, wr_addr_o, wr_data_o}, {8'h00, e});
        end
      end
    end
  end

  // Ready driver: forced level, or random with at most 2 stall cycles in a
  // row so a loaded write always drains well before the next byte (>= 8 cycles).
  initial begin
    int stall;
    stall = 0;
    wr_rdy_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode) begin
        if (stall >= 2 || $urandom_range(0, 1) == 1) begin
          wr_rdy_i = 1'b1;
          stall = 0;
        end else begin
          wr_rdy_i = 1'b0;
          stall++;
        end
      end else begin
        wr_rdy_i = rdy_force;
      end
    end
  end

  // ---------------- reference model ----------------
  // Frame-level view: opcode decides the mode, two address bytes, then one
  // write per remaining byte (no overruns when ready never stalls long).
  task automatic model_frame();
    logic [7:0]  op;
    logic [15:0] a;
    if (frm_q.size() == 0) return;
    op = frm_q[0];
    if (op != 8'h02 && op != 8'h03 && op != 8'h00) begin
      exp_err[0] = 1'b1;
      exp_errs++;
      return;
    end
    exp_frames++;
    if (op == 8'h00 || frm_q.size() < 3) return;
    a = {frm_q[1], frm_q[2]};
    for (int i = 3; i < frm_q.size(); i++) begin
      exp_q.push_back({a, frm_q[i]});
      if (op == 8'h02) a = a + 16'd1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ss_low();
    spi_ss = 1'b0;
    repeat (SS_SYNC + 3) tick();
  endtask

  task automatic ss_high();
    spi_ss = 1'b1;
    repeat (SS_SYNC + 3) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit lat);
    byte_i     = b;
    byte_vld_i = 1'b1;
    tick();
    byte_vld_i = 1'b0;
    byte_i     = 8'($urandom);
    if (lat) begin
      chk("wr_latency", {31'd0, wr_vld_o}, 32'd1);
      tick();
      chk("wr_vld_drop", {31'd0, wr_vld_o}, 32'd0);
      repeat (8) tick();
    end else begin
      repeat (9) tick();
    end
  endtask

  task automatic err_clear();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    exp_err = 2'b00;
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    chk("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic chk_stats();
`ifdef SPI_CMD_STATS_EN
    chk("frame_cnt", {16'd0, frame_cnt_o}, exp_frames);
    chk("err_cnt", {16'd0, err_cnt_o}, exp_errs);
`else
    chk("frame_cnt", {16'd0, frame_cnt_o}, 0);
    chk("err_cnt", {16'd0, err_cnt_o}, 0);
`endif
  endtask

  task automatic run_frame();
    model_frame();
    ss_low();
    foreach (frm_q[i]) send_byte(frm_q[i], 1'b0);
    ss_high();
    drain();
    tick();
    chk("busy_idle", {31'd0, busy_o}, 32'd0);
    chk("err", {30'd0, err_o}, {30'd0, exp_err});
    chk_stats();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w0;
    logic [7:0] op;
    int len;
    rst        = 1'b1;
    spi_ss     = 1'b1;
    byte_vld_i = 1'b0;
    byte_i     = 8'h00;
    err_clr_i  = 1'b0;
    repeat (3) tick();
    chk("rst_wr_vld", {31'd0, wr_vld_o}, 32'd0);
    chk("rst_wr_addr", {16'd0, wr_addr_o}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_err", {30'd0, err_o}, 32'd0);
    chk_stats();
    rst = 1'b0;
    tick();

    // Incrementing burst.
    frm_q = '{8'h02, 8'h12, 8'h34, 8'hAA, 8'hBB};
    run_frame();
    // Address wrap.
    frm_q = '{8'h02, 8'hFF, 8'hFF, 8'h11, 8'h22};
    run_frame();
    // Fixed address burst.
    frm_q = '{8'h03, 8'h00, 8'h40, 8'($urandom), 8'($urandom), 8'($urandom)};
    run_frame();
    // Bad opcode, then clear.
    frm_q = '{8'h7E, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    run_frame();
    err_clear();
    chk("err_clr", {30'd0, err_o}, 32'd0);

    // Overrun: ready low across two data bytes; dropped byte does not
    // advance the address.
    rdy_force = 1'b0;
    exp_frames++;
    exp_errs++;
    exp_q.push_back({16'hA000, 8'hD1});
    ss_low();
    send_byte(8'h02, 1'b0);
    send_byte(8'hA0, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hD1, 1'b0);
    chk("held_vld", {31'd0, wr_vld_o}, 32'd1);
    send_byte(8'hD2, 1'b0);
    exp_err[1] = 1'b1;
    chk("held_slot", {8'h00, wr_addr_o, wr_data_o}, {8'h00, 24'hA000D1});
    chk("ovr_err", {30'd0, err_o}, 32'd2);
    chk("busy_pending", {31'd0, busy_o}, 32'd1);
    w0 = n_wr;
    rdy_force = 1'b1;
    repeat (4) tick();
    chk("ovr_one_write", n_wr - w0, 1);
    chk("ovr_vld_low", {31'd0, wr_vld_o}, 32'd0);
    exp_q.push_back({16'hA001, 8'hD3});
    send_byte(8'hD3, 1'b0);
    ss_high();
    drain();
    chk_stats();

    // Set wins over a simultaneous clear.
    ss_low();
    byte_i     = 8'h7E;
    byte_vld_i = 1'b1;
    err_clr_i  = 1'b1;
    tick();
    byte_vld_i = 1'b0;
    err_clr_i  = 1'b0;
    exp_err    = 2'b01;
    exp_errs++;
    chk("set_wins", {30'd0, err_o}, 32'd1);
    ss_high();
    chk_stats();
    err_clear();

    // Frame ending after ADDR_H issues no write.
    frm_q = '{8'h02, 8'h12};
    run_frame();

    // Single write with latency check.
    frm_q = '{8'h02, 8'h00, 8'h10, 8'h55};
    model_frame();
    ss_low();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    chk("pre_write_vld", {31'd0, wr_vld_o}, 32'd0);
    send_byte(8'h55, 1'b1);
    ss_high();
    drain();
    chk_stats();

    // Random frames with random ready.
    rdy_mode = 1'b1;
    repeat (25) begin
      case ($urandom_range(0, 3))
        0: op = 8'h02;
        1: op = 8'h03;
        2: op = 8'h00;
        default: begin
          op = 8'($urandom);
          while (op == 8'h00 || op == 8'h02 || op == 8'h03) op = 8'($urandom);
        end
      endcase
      frm_q.delete();
      if ($urandom_range(0, 9) != 0) begin
        frm_q.push_back(op);
        frm_q.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
        frm_q.push_back(($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom));
        len = $urandom_range(0, 4);
        for (int i = 0; i < len; i++) frm_q.push_back(8'($urandom));
        if ($urandom_range(0, 5) == 0) frm_q = frm_q[0:$urandom_range(0, 1)];
      end
      run_frame();
      if (exp_err != 2'b00) err_clear();
    end
    rdy_mode  = 1'b0;
    rdy_force = 1'b0;
    repeat (2) tick();

    // Reset while a write is held in the slot.
    ss_low();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h66, 1'b0);
    chk("pre_rst_vld", {31'd0, wr_vld_o}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_vld", {31'd0, wr_vld_o}, 32'd0);
    chk("rst_async_busy", {31'd0, busy_o}, 32'd0);
    exp_frames = 0;
    exp_errs   = 0;
    exp_err    = 2'b00;
    spi_ss     = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    rdy_force = 1'b1;
    repeat (5) tick();
    chk("post_rst_vld", {31'd0, wr_vld_o}, 32'd0);
    chk("post_rst_err", {30'd0, err_o}, 32'd0);
    chk_stats();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_cmd_ctrl.md
# spi_cmd_ctrl

Command sequencer that sits between the `spi_slave` byte receiver and the on-chip register/memory write bus. It frames the received byte stream using the SPI slave-select line, decodes an opcode and 16-bit address, and issues one bus write per data byte with a valid/ready handshake. It also reports malformed frames and lost bytes.

## Interface
Parameters:
- `ADDR_W`, 16: write-bus address width. Must be 16; the address is always received as two bytes.
- `SS_SYNC`, 2: number of synchronizer flops on `spi_ss`. Minimum 2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `spi_ss`  in  1  raw slave select from the pad; active low. Asynchronous to `clk`.
- `byte_vld_i`  in  1  one-cycle strobe from `spi_slave` (`data_en_o`).
- `byte_i`  in  8  received byte (`data_o`); valid only while `byte_vld_i` = 1.
- `wr_vld_o`  out  1  write request.
- `wr_addr_o`  out  16  write address.
- `wr_data_o`  out  8  write data.
- `wr_rdy_i`  in  1  bus accepts the write.
- `busy_o`  out  1  high when the FSM is not in IDLE, or when `wr_vld_o` = 1.
- `err_o`  out  2  sticky flags: [0] bad opcode, [1] overrun.
- `err_clr_i`  in  1  synchronous clear of `err_o`.
- `frame_cnt_o`  out  16  count of completed frames (see Configuration).
- `err_cnt_o`  out  16  count of error events (see Configuration).

## Operation
- `spi_ss` passes through `SS_SYNC` flops. The falling edge of the synchronized signal starts a frame; the rising edge ends it.
- FSM states: IDLE, CMD, ADDR_H, ADDR_L, DATA, DISCARD.
- IDLE → CMD on frame start.
- CMD, on the first byte:
  - 0x02: burst write with auto-increment → ADDR_H.
  - 0x03: burst write to a fixed address (FIFO port) → ADDR_H.
  - 0x00: no-op → DISCARD.
  - Any other value: set `err_o[0]` → DISCARD.
- ADDR_H captures address[15:8], then ADDR_L captures address[7:0], then the FSM enters DATA.
- DATA: each byte loads the single output slot (`wr_vld_o`, `wr_addr_o`, `wr_data_o`) with the current address.
  - Opcode 0x02: the address increments by 1 after each loaded byte and wraps from 0xFFFF to 0x0000.
  - Opcode 0x03: the address is held.
- DISCARD ignores all bytes until the frame ends.
- Frame end, in any state, → IDLE. A write already loaded in the slot stays valid until the bus accepts it. A frame that ends before ADDR_L completes issues no write.
- Overrun: a DATA byte arrives while `wr_vld_o` = 1 and `wr_rdy_i` = 0.
  - The byte is dropped and `err_o[1]` is set.
  - The address does not advance.
  - If `wr_rdy_i` = 1 in that same cycle, the new byte loads the slot and no overrun is flagged.
- `err_clr_i` clears both flags. If a set event occurs in the same cycle as the clear, the set wins.
- A new frame start during any non-IDLE state (ss glitch) restarts at CMD.

## Timing
- Reset values:
  - `wr_vld_o` = 0; `wr_addr_o` = 0; `wr_data_o` = 0.
  - `busy_o` = 0; `err_o` = 0; both counters = 0.
  - FSM = IDLE; synchronizer flops = 1.
- Frame detection latency: `SS_SYNC` + 1 cycles from the `spi_ss` edge.
- Write latency: `byte_vld_i` in cycle N (state DATA) → `wr_vld_o` = 1 in cycle N+1.
- `wr_vld_o` stays high, with address and data stable, until the cycle in which `wr_rdy_i` = 1. It drops in the next cycle unless a new byte reloads the slot in that same cycle.
- Consecutive `byte_vld_i` strobes are at least 8 `clk` cycles apart, guaranteed by `spi_slave`.
- The block needs no more than 1 `byte_vld_i` per cycle.

## Configuration
- Macro: `SPI_CMD_STATS_EN`.
- Defined:
  - `frame_cnt_o` increments on each frame end that was preceded by a valid opcode.
  - `err_cnt_o` increments on each bad-opcode or overrun event.
  - Both counters saturate at 0xFFFF and are cleared only by `rst`.
- Undefined: both ports are present and tied to 0, and no counter logic is synthesized.

## Structure
- Package `spi_cmd_pkg` holds:
  - Opcode constants `OP_WR_INC` = 0x02, `OP_WR_FIX` = 0x03, `OP_NOP` = 0x00.
  - The FSM state enum.
  - Error-bit index constants.
- Sub-module `spi_cmd_ss_sync` contains the `SS_SYNC`-stage synchronizer and produces one-cycle `frame_start` and `frame_end` pulses.

## Test plan
- Frame 0x02, 0x12, 0x34, 0xAA, 0xBB with `wr_rdy_i` held at 1 → two writes: (0x1234, 0xAA) then (0x1235, 0xBB). `err_o` = 0.
- Frame 0x02, 0xFF, 0xFF, 0x11, 0x22 → writes to 0xFFFF then 0x0000.
- Frame 0x03, 0x00, 0x40, then three data bytes → three writes, all to 0x0040.
- Opcode 0x7E followed by 4 bytes → no writes; `err_o` = 2'b01. Assert `err_clr_i` → `err_o` = 0.
- Opcode 0x02, then `wr_rdy_i` = 0 across two data bytes → the first write is held, the second byte is dropped, and `err_o[1]` = 1. When `wr_rdy_i` rises, exactly 1 write completes.
- `spi_ss` raised after ADDR_H only → no write. Next frame 0x02, 0x00, 0x10, 0x55 → write (0x0010, 0x55). Assert `rst` mid-write → `wr_vld_o` = 0 immediately.
